// File: rtl/find_max_pkg.sv
// ---------------------------------------------------------------------------
// find_max_pkg : shared defaults, state encoding and counter sizing (rev 1.0)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package find_max_pkg;

  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  // Width able to represent 0..frame_len, never less than one bit.
  function automatic int cnt_width(input int frame_len);
    int w;
    w = $clog2(frame_len + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/find_max_unit_if.sv
// ---------------------------------------------------------------------------
// find_max_unit_if : sample-in / result-out vld-busy channels (rev 1.0)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface find_max_unit_if import find_max_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);

  logic              x_in_vld;
  logic              x_in_busy;
  logic [DATA_W-1:0] x_in_data;
  logic              ret_out_vld;
  logic              ret_out_busy;
  logic [DATA_W-1:0] ret_out_data;

  modport master (
    output x_in_vld, x_in_data, ret_out_busy,
    input  x_in_busy, ret_out_vld, ret_out_data
  );

  modport slave (
    input  x_in_vld, x_in_data, ret_out_busy,
    output x_in_busy, ret_out_vld, ret_out_data
  );

endinterface

`default_nettype wire

// File: rtl/find_max_unit.sv
// ---------------------------------------------------------------------------
// find_max_unit : signed maximum of each FRAME_LEN-sample frame (rev 1.0)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module find_max_unit import find_max_pkg::*; #(
  parameter int FRAME_LEN = 8,
  parameter int DATA_W    = DATA_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  find_max_unit_if.slave bus
);

  localparam int               CNT_W    = cnt_width(FRAME_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_e                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [DATA_W-1:0] max_q, max_d;
  logic                     x_in_busy_q, x_in_busy_d;
  logic                     ret_out_vld_q, ret_out_vld_d;
  logic [DATA_W-1:0]        ret_out_data_q, ret_out_data_d;

  logic                     x_fire;
  logic                     ret_fire;
  logic signed [DATA_W-1:0] sample;
  logic signed [DATA_W-1:0] next_max;

  assign sample   = $signed(bus.x_in_data);
  assign x_fire   = bus.x_in_vld & ~x_in_busy_q;
  assign ret_fire = ret_out_vld_q & ~bus.ret_out_busy;
  // First sample of a frame seeds the running max regardless of value.
  assign next_max = ((count_q == '0) || (sample > max_q)) ? sample : max_q;

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    max_d          = max_q;
    ret_out_data_d = ret_out_data_q;

    case (state_q)
      ST_IDLE: begin
        state_d = ST_ACCUM;
      end
      ST_ACCUM: begin
        if (x_fire) begin
          max_d = next_max;
          if (count_q == LAST_CNT) begin
            state_d        = ST_RESULT;
            count_d        = '0;
            ret_out_data_d = next_max;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      ST_RESULT: begin
        if (ret_fire) begin
          state_d = ST_ACCUM;
          count_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Handshake outputs are registered, so they are derived from the next state.
    x_in_busy_d   = (state_d != ST_ACCUM);
    ret_out_vld_d = (state_d == ST_RESULT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      max_q          <= '0;
      x_in_busy_q    <= 1'b1;
      ret_out_vld_q  <= 1'b0;
      ret_out_data_q <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      max_q          <= max_d;
      x_in_busy_q    <= x_in_busy_d;
      ret_out_vld_q  <= ret_out_vld_d;
      ret_out_data_q <= ret_out_data_d;
    end
  end

  assign bus.x_in_busy    = x_in_busy_q;
  assign bus.ret_out_vld  = ret_out_vld_q;
  assign bus.ret_out_data = ret_out_data_q;

endmodule

`default_nettype wire
